// File: rtl/dna_qga_pkg.sv
// Shared definitions for the quantum DNA core and its job dispatcher:
// base/gate encodings, default widths, dispatcher state encoding.
package dna_qga_pkg;

   localparam int DNA_WIDTH_DEF          = 32;
   localparam int AGING_FACTOR_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      BASE_A = 2'b00,
      BASE_T = 2'b01,
      BASE_G = 2'b10,
      BASE_C = 2'b11
   } base_t;

   typedef enum logic [1:0] {
      GATE_HADAMARD = 2'b00,
      GATE_CNOT     = 2'b01,
      GATE_TOFFOLI  = 2'b10,
      GATE_CUSTOM   = 2'b11
   } gate_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RESULT    = 3'd4
   } disp_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/dna_result_reg.sv
// Result capture/hold register: loads the core's outputs and presents them
// on a valid/ready stream, holding them stable until the consumer takes them.
module dna_result_reg
   import dna_qga_pkg::*;
#(
   parameter int DNA_WIDTH = DNA_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [DNA_WIDTH-1:0] load_dna,
   input  logic [15:0]          load_entropy,
   input  logic [7:0]           load_mutations,
   input  logic                 load_timeout,
   input  logic                 present,
   input  logic                 res_ready,
   output logic                 res_valid,
   output logic [DNA_WIDTH-1:0] res_dna,
   output logic [15:0]          res_entropy,
   output logic [7:0]           res_mutations,
   output logic                 res_timeout,
   output logic                 fire
);

   assign fire = res_valid && res_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid     <= 1'b0;
         res_dna       <= '0;
         res_entropy   <= '0;
         res_mutations <= '0;
         res_timeout   <= 1'b0;
      end else begin
         if (load) begin
            res_dna       <= load_dna;
            res_entropy   <= load_entropy;
            res_mutations <= load_mutations;
            res_timeout   <= load_timeout;
         end
         if (present)
            res_valid <= 1'b1;
         else if (fire)
            res_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dna_job_dispatcher.sv
// Host-side initiator for the DNA processing core: job stream in, level start/done
// to the core, tagged result stream out. Optional watchdog: DNA_DISPATCH_TIMEOUT_EN.
module dna_job_dispatcher
   import dna_qga_pkg::*;
#(
   parameter int DNA_WIDTH          = DNA_WIDTH_DEF,
   parameter int AGING_FACTOR_WIDTH = AGING_FACTOR_WIDTH_DEF,
   parameter int TAG_WIDTH          = 8,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          job_valid,
   output logic                          job_ready,
   input  logic [DNA_WIDTH-1:0]          job_dna,
   input  logic [AGING_FACTOR_WIDTH-1:0] job_aging,
   input  logic [1:0]                    job_gate,
   output logic                          core_start,
   output logic [DNA_WIDTH-1:0]          core_dna,
   output logic [AGING_FACTOR_WIDTH-1:0] core_aging,
   output logic [1:0]                    core_gate,
   input  logic                          core_done,
   input  logic [DNA_WIDTH-1:0]          core_result,
   input  logic [15:0]                   core_entropy,
   input  logic [7:0]                    core_mutations,
   output logic                          core_abort,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [TAG_WIDTH-1:0]          res_tag,
   output logic [DNA_WIDTH-1:0]          res_dna,
   output logic [15:0]                   res_entropy,
   output logic [7:0]                    res_mutations,
   output logic                          res_timeout,
   output logic                          busy,
   output logic [15:0]                   jobs_done
);

   disp_state_t          state, state_n;
   logic [TAG_WIDTH-1:0] tag_cnt;
   logic                 accept, capture, timeout_load, present, res_fire, timeout_hit;

   assign job_ready  = (state == ST_IDLE) && !core_done && !rst;
   assign accept     = job_valid && job_ready;
   assign core_start = (state == ST_ISSUE) || (state == ST_WAIT_DONE);
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n      = state;
      capture      = 1'b0;
      timeout_load = 1'b0;
      present      = 1'b0;
      unique case (state)
         ST_IDLE:      if (accept) state_n = ST_ISSUE;
         ST_ISSUE:     state_n = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (core_done) begin
               capture = 1'b1;
               state_n = ST_RELEASE;
            end else if (timeout_hit) begin
               timeout_load = 1'b1;
               present      = 1'b1;
               state_n      = ST_RESULT;
            end
         end
         ST_RELEASE: begin
            // Result is only offered once the core has returned to its idle (done low).
            if (!core_done) begin
               present = 1'b1;
               state_n = ST_RESULT;
            end else if (timeout_hit) begin
               timeout_load = 1'b1;
               present      = 1'b1;
               state_n      = ST_RESULT;
            end
         end
         ST_RESULT:    if (res_fire) state_n = ST_IDLE;
         default:      state_n = ST_IDLE;
      endcase
   end

   // Operands and tag frozen from accept until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_dna   <= '0;
         core_aging <= '0;
         core_gate  <= '0;
         res_tag    <= '0;
         tag_cnt    <= '0;
         jobs_done  <= '0;
      end else begin
         if (accept) begin
            core_dna   <= job_dna;
            core_aging <= job_aging;
            core_gate  <= job_gate;
            res_tag    <= tag_cnt;
         end
         if (res_fire) begin
            tag_cnt   <= tag_cnt + 1'b1;
            jobs_done <= sat_inc16(jobs_done);
         end
      end
   end

`ifdef DNA_DISPATCH_TIMEOUT_EN
   logic [15:0] to_cnt;
   logic        abort_q;

   assign timeout_hit = ((state == ST_WAIT_DONE) || (state == ST_RELEASE)) &&
                        (to_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign core_abort  = abort_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt  <= '0;
         abort_q <= 1'b0;
      end else begin
         abort_q <= timeout_load;
         if (state_n != state)
            to_cnt <= '0;
         else if ((state == ST_WAIT_DONE) || (state == ST_RELEASE))
            to_cnt <= to_cnt + 16'd1;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout_hit        = 1'b0;
   assign core_abort         = 1'b0;
`endif

   dna_result_reg #(
      .DNA_WIDTH (DNA_WIDTH)
   ) u_result (
      .clk            (clk),
      .rst            (rst),
      .load           (capture || timeout_load),
      .load_dna       (timeout_load ? '0 : core_result),
      .load_entropy   (timeout_load ? 16'd0 : core_entropy),
      .load_mutations (timeout_load ? 8'd0 : core_mutations),
      .load_timeout   (timeout_load),
      .present        (present),
      .res_ready      (res_ready),
      .res_valid      (res_valid),
      .res_dna        (res_dna),
      .res_entropy    (res_entropy),
      .res_mutations  (res_mutations),
      .res_timeout    (res_timeout),
      .fire           (res_fire)
   );

endmodule

// File: doc/dna_job_dispatcher.md
# dna_job_dispatcher

Host-side initiator for the quantum DNA processing core. Accepts jobs (DNA word, aging factor, gate select) on a valid/ready stream and drives the core's level-sensitive start/done handshake. Holds the operands stable for the whole run, captures the results, and returns them on a tagged valid/ready result stream. Sits between the host/DMA job queue and one processing core instance.

## Interface
- DNA_WIDTH, 32, DNA word width (2 bits per base); must match the core.
- AGING_FACTOR_WIDTH, 8, aging factor width; must match the core.
- TAG_WIDTH, 8, job tag width.
- TIMEOUT_CYCLES, 1024, maximum wait for core done (used only when the timeout feature is compiled in).
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- job_valid  in  1  job offered.
- job_ready  out  1  dispatcher can accept a job.
- job_dna  in  DNA_WIDTH  sequence.
- job_aging  in  AGING_FACTOR_WIDTH  aging factor.
- job_gate  in  2  gate select (00 Hadamard, 01 CNOT, 10 Toffoli, 11 Custom).
- core_start  out  1  core start level.
- core_dna  out  DNA_WIDTH  held operand.
- core_aging  out  AGING_FACTOR_WIDTH  held operand.
- core_gate  out  2  held operand.
- core_done  in  1  core processing_done.
- core_result  in  DNA_WIDTH  core processed_dna.
- core_entropy  in  16  core entropy_measure.
- core_mutations  in  8  core mutation_count.
- core_abort  out  1  one-cycle core recovery pulse (timeout feature only; tied 0 otherwise).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_tag  out  TAG_WIDTH  tag of the job.
- res_dna / res_entropy / res_mutations  out  DNA_WIDTH / 16 / 8  captured results.
- res_timeout  out  1  job terminated by timeout; data fields are zero.
- busy  out  1  state != IDLE.
- jobs_done  out  16  completed-job count (saturates at 16'hFFFF).

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RELEASE, RESULT.
- IDLE: job_ready = !core_done. A stale done blocks acceptance. On job_valid && job_ready: latch the operands into core_* and the tag counter into res_tag, then go to ISSUE.
- ISSUE: core_start=1; go to WAIT_DONE.
- WAIT_DONE: core_start stays 1 and the operands stay frozen. On core_done=1: capture result/entropy/mutations, set res_timeout=0, drop core_start, go to RELEASE.
- RELEASE: core_start=0. Wait for core_done=0, then go to RESULT. This matches the core's DONE→IDLE return.
- RESULT: res_valid=1 and all res_* are held stable. On res_ready: jobs_done += 1 (saturating), tag counter += 1 (wraps max→0), go to IDLE.
- The tag advances only on result handshake, so a res_tag value is never reused while its result is pending.
- job_valid while busy: ignored (job_ready=0). res_ready without res_valid: ignored.

## Timing
- Reset values: core_start 0, core_* operands 0, core_abort 0, job_ready 0 during reset, res_valid 0, res_* 0, busy 0, jobs_done 0, tag counter 0, state IDLE.
- Reset mid-job: core_start drops asynchronously and the job is discarded with no result.
- Accept to core_start high: 1 cycle (ISSUE registered).
- Core done to res_valid: at least 2 cycles (capture, then done-low observed).
- Earliest next accept: cycle after res handshake.
- Results are registered; no combinational path from core_* to res_*.

## Configuration
- DNA_DISPATCH_TIMEOUT_EN defined: a 16-bit counter runs in WAIT_DONE and RELEASE and clears on state entry.
- On reaching TIMEOUT_CYCLES: drop core_start, pulse core_abort for 1 cycle, zero the data fields, set res_timeout=1, go to RESULT.
- Undefined: no counter, core_abort tied 0, res_timeout tied 0, waits indefinitely.

## Structure
- Shared package dna_qga_pkg: base encodings (A=00, T=01, G=10, C=11), gate codes, DNA_WIDTH/AGING_FACTOR_WIDTH defaults, dispatcher state encoding. The core uses the same package.
- Sub-module dna_result_reg: result capture/hold register with valid/ready output side.

## Test plan
- Single job: dna=32'h1234_5678, aging=8'h40, gate=01. Bench core model asserts done after 12 cycles with result=dna^32'hFFFF_FFFF, entropy=16'hFF00, mutations=3. Expect res_dna=32'hEDCB_A987, res_entropy=16'hFF00, res_mutations=3, res_tag=0, jobs_done=1.
- Operand stability: change job_* inputs every cycle during WAIT_DONE. Expect core_dna/aging/gate constant and core_start continuously 1.
- Backpressure: res_ready=0 for 20 cycles. Expect res_valid held, job_ready=0, core_start=0. Release res_ready, then expect an accept the cycle after the handshake.
- Tag wrap: run 257 jobs. Expect tags 0..255 then 0, and jobs_done=257.
- Stale done / reset: hold core_done=1 in IDLE and expect job_ready=0. Assert rst mid-WAIT_DONE and expect core_start=0 immediately with no res_valid.
- With DNA_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, core never asserts done. Expect core_abort pulse and res_valid with res_timeout=1 and res_dna=0, 16 cycles after WAIT_DONE entry.
